// File: rtl/intc_csr_pkg.sv
// Shared constants for the I2C-attached interrupt controller CSR block.
package intc_csr_pkg;

  localparam int CSR_AW = 5;

  typedef enum logic [1:0] {
    OFS_IE    = 2'd0,
    OFS_IP    = 2'd1,
    OFS_IPOL  = 2'd2,
    OFS_ITYPE = 2'd3
  } reg_ofs_e;

  function automatic logic [7:0] irq_mask(input int n);
    return 8'((1 << n) - 1);
  endfunction

endpackage

// File: rtl/intc_sync.sv
// Width-parameterized two-flop synchronizer for asynchronous interrupt inputs.
module intc_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/intc_csr.sv
// Interrupt controller CSR block: IE / IP / IPOL / ITYPE at BASE..BASE+3.
// Edge-triggered sources and the ITYPE register exist only when INTC_EDGE_EN is defined.
module intc_csr
  import intc_csr_pkg::*;
#(
  parameter logic [CSR_AW-1:0] BASE    = 5'h1c,
  parameter int                NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CSR_AW-1:0]  csr_a,
  input  logic               csr_we,
  input  logic [7:0]         csr_do,
  output logic [7:0]         csr_di,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out
);

  localparam logic [7:0] MASK = irq_mask(NUM_IRQ);

  logic [NUM_IRQ-1:0] sync;
  logic [7:0]         ie, ip, ipol, itype;
  logic [7:0]         act, wdata, ip_nxt, rdata;
  logic               in_blk, wr;
  reg_ofs_e           ofs;

  intc_sync #(.WIDTH(NUM_IRQ)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (irq_in),
    .q   (sync)
  );

  assign in_blk = (csr_a[CSR_AW-1:2] == BASE[CSR_AW-1:2]);
  assign ofs    = reg_ofs_e'(csr_a[1:0]);
  assign wr     = csr_we & in_blk;
  assign wdata  = csr_do & MASK;
  assign act    = 8'(sync) ^ ipol;

`ifdef INTC_EDGE_EN
  logic [7:0] hist, rise, w1c, ipol_nxt;

  assign ipol_nxt = (wr && ofs == OFS_IPOL) ? wdata : ipol;
  assign w1c      = (wr && ofs == OFS_IP) ? wdata : 8'h00;
  assign rise     = act & ~hist & itype;
  // A new edge outranks a clear arriving in the same cycle.
  assign ip_nxt   = (act & ~itype) | rise | (itype & ip & ~w1c);

  // History follows the polarity that will be in force next cycle, so a
  // polarity flip never looks like a source transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist  <= 8'h00;
      itype <= 8'h00;
    end else begin
      hist <= 8'(sync) ^ ipol_nxt;
      if (wr && ofs == OFS_ITYPE) itype <= wdata;
    end
  end
`else
  assign itype  = 8'h00;
  assign ip_nxt = act;
`endif

  always_comb begin
    case (ofs)
      OFS_IE:   rdata = ie;
      OFS_IP:   rdata = ip;
      OFS_IPOL: rdata = ipol;
      default:  rdata = itype;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie      <= 8'h00;
      ipol    <= 8'h00;
      ip      <= 8'h00;
      csr_di  <= 8'h00;
      irq_out <= 1'b0;
    end else begin
      if (wr && ofs == OFS_IE)   ie   <= wdata;
      if (wr && ofs == OFS_IPOL) ipol <= wdata;
      ip      <= ip_nxt & MASK;
      csr_di  <= in_blk ? rdata : 8'h00;
      irq_out <= |(ip & ie);
    end
  end

endmodule

// File: tb/tb_intc_csr.sv
// Randomized plus directed bench for intc_csr against a cycle-level reference model.
module tb_intc_csr;

  localparam logic [4:0] BASE    = 5'h1c;
  localparam int         NUM_IRQ = 6;
  localparam logic [7:0] MASK    = 8'h3f;
`ifdef INTC_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [4:0]         csr_a;
  logic               csr_we;
  logic [7:0]         csr_do;
  logic [7:0]         csr_di;
  logic [NUM_IRQ-1:0] irq_in;
  logic               irq_out;

  int  n_chk  = 0;
  int  n_fail = 0;
  bit  chk_en = 1'b0;

  intc_csr #(.BASE(BASE), .NUM_IRQ(NUM_IRQ)) dut (
    .clk     (clk),
    .rst     (rst),
    .csr_a   (csr_a),
    .csr_we  (csr_we),
    .csr_do  (csr_do),
    .csr_di  (csr_di),
    .irq_in  (irq_in),
    .irq_out (irq_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: registers as plain bytes, synchronizer as a two-deep delay line.
  logic [7:0]         m_ie, m_ip, m_ipol, m_itype, m_rd;
  logic               m_out;
  logic [NUM_IRQ-1:0] m_s1, m_s2, m_prev;
  logic [7:0]         m_act, m_nie, m_nipol, m_nitype, m_nip, m_w1c, m_rdv;
  logic [NUM_IRQ-1:0] m_nprev;
  bit                 m_hit;
  int                 m_off;

  always_comb begin
    m_act   = 8'(m_s2) ^ m_ipol;
    m_hit   = (int'(csr_a) >= int'(BASE)) && (int'(csr_a) <= int'(BASE) + 3);
    m_off   = int'(csr_a) - int'(BASE);
    m_nie   = m_ie;
    m_nipol = m_ipol;
    m_nitype = m_itype;
    m_w1c   = 8'h00;
    m_nip   = 8'h00;
    m_rdv   = 8'h00;
    if (csr_we && m_hit) begin
      case (m_off)
        0: m_nie   = csr_do & MASK;
        1: m_w1c   = csr_do & MASK;
        2: m_nipol = csr_do & MASK;
        3: if (EDGE) m_nitype = csr_do & MASK;
        default: ;
      endcase
    end
    for (int b = 0; b < NUM_IRQ; b++) begin
      if (m_itype[b]) begin
        if (m_act[b] && !m_prev[b]) m_nip[b] = 1'b1;
        else if (m_w1c[b])          m_nip[b] = 1'b0;
        else                        m_nip[b] = m_ip[b];
      end else begin
        m_nip[b] = m_act[b];
      end
    end
    m_nprev = m_s2 ^ m_nipol[NUM_IRQ-1:0];
    if (m_hit) begin
      case (m_off)
        0: m_rdv = m_ie;
        1: m_rdv = m_ip;
        2: m_rdv = m_ipol;
        default: m_rdv = m_itype;
      endcase
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ie <= '0; m_ip <= '0; m_ipol <= '0; m_itype <= '0; m_rd <= '0;
      m_out <= 1'b0; m_s1 <= '0; m_s2 <= '0; m_prev <= '0;
    end else begin
      m_ie    <= m_nie;
      m_ipol  <= m_nipol;
      m_itype <= m_nitype;
      m_ip    <= m_nip;
      m_rd    <= m_rdv;
      m_out   <= |(m_ip & m_ie);
      m_prev  <= m_nprev;
      m_s2    <= m_s1;
      m_s1    <= irq_in;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("model_csr_di", csr_di, m_rd);
      check("model_irq_out", 8'(irq_out), 8'(m_out));
    end
  end

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    csr_a = a; csr_do = d; csr_we = 1'b1;
    @(negedge clk);
    csr_we = 1'b0;
  endtask

  task automatic rd_chk(input logic [4:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk);
    csr_a = a;
    @(posedge clk);
    #1 check(tag, csr_di, exp);
  endtask

  task automatic out_after(input int n, input logic exp, input string tag);
    repeat (n) @(posedge clk);
    #1 check(tag, 8'(irq_out), 8'(exp));
  endtask

  initial begin
    rst = 1'b1; csr_a = '0; csr_we = 1'b0; csr_do = '0; irq_in = '0;
    repeat (3) @(negedge clk);
    check("rst_csr_di", csr_di, 8'h00);
    check("rst_irq_out", 8'(irq_out), 8'h00);
    rst = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 4; i++) rd_chk(5'(BASE + i), 8'h00, "rst_reg");

    // Unimplemented high bits.
    wr(BASE + 0, 8'hff);
    rd_chk(BASE + 0, MASK, "ie_mask");

    // Level source, four-cycle latency in both directions.
    wr(BASE + 0, 8'h01);
    @(negedge clk) irq_in[0] = 1'b1;
    out_after(3, 1'b0, "lvl_rise_early");
    out_after(1, 1'b1, "lvl_rise_4clk");
    rd_chk(BASE + 1, 8'h01, "lvl_ip");
    @(negedge clk) irq_in[0] = 1'b0;
    out_after(3, 1'b1, "lvl_fall_early");
    out_after(1, 1'b0, "lvl_fall_4clk");

    // One-clock pulse on an edge source, then W1C.
    wr(BASE + 3, 8'h02);
    rd_chk(BASE + 3, EDGE ? 8'h02 : 8'h00, "itype_rd");
    wr(BASE + 0, 8'h02);
    @(negedge clk) irq_in[1] = 1'b1;
    @(negedge clk) irq_in[1] = 1'b0;
    repeat (5) @(negedge clk);
    rd_chk(BASE + 1, EDGE ? 8'h02 : 8'h00, "edge_latched");
    check("edge_irq_out", 8'(irq_out), EDGE ? 8'h01 : 8'h00);
    wr(BASE + 1, 8'h02);
    check("w1c_out_lag", 8'(irq_out), EDGE ? 8'h01 : 8'h00);
    out_after(1, 1'b0, "w1c_out_clear");
    rd_chk(BASE + 1, 8'h00, "w1c_ip");

    // Edge arriving in the same cycle as its clear.
    @(negedge clk) irq_in[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    csr_a = BASE + 1; csr_do = 8'h02; csr_we = 1'b1;
    @(negedge clk) csr_we = 1'b0;
    rd_chk(BASE + 1, 8'h02, "set_beats_w1c");
    @(negedge clk) irq_in[1] = 1'b0;
    repeat (4) @(negedge clk);
    wr(BASE + 1, 8'h02);
    rd_chk(BASE + 1, 8'h00, "ip_cleared");

    // Active-low source, then an out-of-block write.
    wr(BASE + 2, 8'h04);
    wr(BASE + 0, 8'h04);
    repeat (4) @(negedge clk);
    check("ipol_irq_out", 8'(irq_out), 8'h01);
    wr(5'h00, 8'hff);
    rd_chk(5'h00, 8'h00, "oob_read");
    rd_chk(BASE + 0, 8'h04, "oob_ie");
    rd_chk(BASE + 2, 8'h04, "oob_ipol");
    rd_chk(BASE + 3, EDGE ? 8'h02 : 8'h00, "oob_itype");
    rd_chk(BASE + 1, 8'h04, "oob_ip");

    // Asynchronous reset while an interrupt is pending.
    wr(BASE + 2, 8'h00);
    wr(BASE + 0, 8'h02);
    @(negedge clk) irq_in[1] = 1'b1;
    repeat (6) @(negedge clk);
    rd_chk(BASE + 1, 8'h02, "pre_rst_ip");
    check("pre_rst_out", 8'(irq_out), 8'h01);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out", 8'(irq_out), 8'h00);
    check("async_rst_di", csr_di, 8'h00);
    irq_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) rd_chk(5'(BASE + i), 8'h00, "post_rst_reg");

    // Random traffic checked cycle by cycle against the model.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ NUM_IRQ'($urandom);
      csr_we = ($urandom_range(0, 3) == 0);
      csr_a  = ($urandom_range(0, 3) != 0) ? 5'(BASE + $urandom_range(0, 3)) : 5'($urandom);
      csr_do = 8'($urandom);
    end
    @(negedge clk) csr_we = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/intc_csr.md
INTC_CSR -- requirements
Module: intc_csr

Interface
REQ-001 SHALL have parameter BASE, default 5'h1c, CSR address of register 0 (block occupies BASE..BASE+3; BASE SHALL be 4-aligned).
REQ-002 SHALL have parameter NUM_IRQ, default 8, number of interrupt inputs (1..8).
REQ-003 SHALL have port clk  input  1  system clock; single clock domain.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port csr_a  input  5  CSR address from the I2C slave.
REQ-006 SHALL have port csr_we  input  1  write strobe, one clk wide.
REQ-007 SHALL have port csr_do  input  8  write data from the I2C slave.
REQ-008 SHALL have port csr_di  output  8  read data to the I2C slave.
REQ-009 SHALL have port irq_in  input  NUM_IRQ  asynchronous interrupt sources.
REQ-010 SHALL have port irq_out  output  1  combined interrupt to host, active-high.

Function
REQ-011 Register map: BASE+0 IE (R/W enable); BASE+1 IP (pending; R, write-1-to-clear); BASE+2 IPOL (R/W, 1 = source active-low); BASE+3 ITYPE (R/W, 1 = edge).
REQ-012 Each irq_in bit SHALL pass a 2-flop synchronizer, then XOR with its IPOL bit, giving active-high "act".
REQ-013 Level bit (ITYPE=0): IP bit equals act, registered; W1C has no effect.
REQ-014 Edge bit (ITYPE=1): IP bit sets on act 0->1 (third flop for detection), stays set until W1C.
REQ-015 Simultaneous edge and W1C on same bit in same clk: set wins, IP stays 1.
REQ-016 Write takes effect the clk after csr_we high; csr_we with csr_a outside BASE..BASE+3 SHALL be ignored.
REQ-017 csr_di SHALL be registered: reflects register at csr_a one clk after csr_a changes; 8'h00 when csr_a outside block (upstream ORs blocks).
REQ-018 Bits at and above NUM_IRQ SHALL read 0 and ignore writes.
REQ-019 irq_out SHALL be registered |(IP & IE); one clk after IP/IE change.
REQ-020 Changing IPOL or ITYPE SHALL NOT itself create an edge: edge detector history reloads with new act the same clk.
REQ-021 Total latency irq_in edge -> irq_out high SHALL be 4 clk (2 sync, 1 IP, 1 output).

Reset
REQ-022 On rst: IE, IP, IPOL, ITYPE, synchronizer and edge flops = 0; csr_di = 8'h00; irq_out = 0.
REQ-023 rst asserted mid-operation SHALL clear all state immediately (async); pending edges are lost.

Configuration
REQ-024 Macro INTC_EDGE_EN compiled in: ITYPE register and edge detection per REQ-014/015/020 present.
REQ-025 Without INTC_EDGE_EN: all bits level-only, BASE+3 reads 8'h00, writes ignored, edge flops absent.

Structure
REQ-026 Shared package SHALL hold register offset constants (IE=0, IP=1, IPOL=2, ITYPE=3) and CSR address width (5).
REQ-027 Sub-module intc_sync (2-flop synchronizer, width-parameterized) SHALL be instantiated once.

Verification
REQ-028 Reset, read BASE+0..3 -> csr_di 8'h00 each; irq_out 0.
REQ-029 Write IE=8'h01, level, raise irq_in[0] -> irq_out 1 after 4 clk; IP reads 8'h01; drop irq_in[0] -> irq_out 0 after 4 clk.
REQ-030 ITYPE=8'h02, IE=8'h02, pulse irq_in[1] 1 clk -> IP 8'h02 latched; write IP=8'h02 -> IP 8'h00, irq_out 0 next clk.
REQ-031 Edge on bit 1 in same clk as W1C of bit 1 -> IP bit 1 stays 1.
REQ-032 IPOL=8'h04, irq_in[2]=0, IE=8'h04 -> irq_out 1; write csr_a=BASE+4 data 8'hff -> no register changes, read returns 8'h00.
REQ-033 Assert rst while IP=8'h02, irq_out=1 -> all outputs 0 immediately, registers read 8'h00 after release.
